// File: rtl/game_pkg.sv
// Shared game definitions: player action state encoding, state width,
// default attack frame counts and saturating position helpers.
// Used by the player action controller, the renderer and the hit detector.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_WALK_L      = 3'd1,
    ST_WALK_R      = 3'd2,
    ST_ATK_STARTUP = 3'd3,
    ST_ATK_ACTIVE  = 3'd4,
    ST_ATK_RECOVER = 3'd5
  } action_state_e;

  localparam logic [3:0] DEF_STARTUP_FR = 4'd4;
  localparam logic [3:0] DEF_ACTIVE_FR  = 4'd3;
  localparam logic [3:0] DEF_RECOVER_FR = 4'd6;

  // Move left by step, clamped at x_min. Done in 11 bits so a position
  // smaller than the step shows up as a borrow instead of wrapping.
  function automatic logic [9:0] step_left(input logic [9:0] pos,
                                           input logic [9:0] step,
                                           input logic [9:0] x_min);
    logic [10:0] diff;
    diff = {1'b0, pos} - {1'b0, step};
    if (diff[10] || (diff[9:0] < x_min)) return x_min;
    return diff[9:0];
  endfunction

  // Move right by step, clamped at x_max; the carry bit prevents wrap.
  function automatic logic [9:0] step_right(input logic [9:0] pos,
                                            input logic [9:0] step,
                                            input logic [9:0] x_max);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (sum > {1'b0, x_max}) return x_max;
    return sum[9:0];
  endfunction

endpackage

// File: rtl/player_action_ctrl_frame_counter.sv
// frame_counter: 4-bit down counter paced by the game frame tick.
// Ports:
//   clk_i, rst_i     - clock, asynchronous active-high reset
//   clear_i          - synchronous clear (player restart), any cycle
//   tick_i           - frame strobe; load/decrement only happen on it
//   load_i, load_val_i - load value on a tick (takes priority over decrement)
//   zero_o           - counter currently reads zero
module frame_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else if (clear_i) begin
      cnt_q <= 4'd0;
    end else if (tick_i) begin
      if (load_i)              cnt_q <= load_val_i;
      else if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/player_action_ctrl.sv
// player_action_ctrl: per-player walk/attack state machine.
// Everything advances on frame_tick_i only; restart_i reloads the reset
// values on the next clock edge regardless of the tick.
// Ports:
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   frame_tick_i        - one-cycle strobe per game frame
//   restart_i           - synchronous restart (level)
//   enable_i            - gameplay running; low forces IDLE and aborts attacks
//   move_left_i/right_i - cleaned direction keys
//   attack_i            - cleaned attack key (level; rising edge triggers)
//   pos_x_o             - player x position
//   state_o             - current action state (game_pkg::action_state_e)
//   hitbox_active_o     - high exactly while in ATK_ACTIVE
//   attack_start_o      - one-cycle pulse after the tick entering ATK_STARTUP
module player_action_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0] X_MIN      = 10'd16,
  parameter logic [9:0] X_MAX      = 10'd560,
  parameter logic [9:0] X_INIT     = 10'd100,
  parameter logic [9:0] WALK_STEP  = 10'd3,
  parameter logic [3:0] STARTUP_FR = DEF_STARTUP_FR,
  parameter logic [3:0] ACTIVE_FR  = DEF_ACTIVE_FR,
  parameter logic [3:0] RECOVER_FR = DEF_RECOVER_FR
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         frame_tick_i,
  input  logic         restart_i,
  input  logic         enable_i,
  input  logic         move_left_i,
  input  logic         move_right_i,
  input  logic         attack_i,
  output logic [9:0]   pos_x_o,
  output logic [2:0]   state_o,
  output logic         hitbox_active_o,
  output logic         attack_start_o
);

  action_state_e state_q, state_d;
  logic [9:0]    pos_q, pos_d;
  logic          prev_attack_q;
  logic          hitbox_q;
  logic          attack_start_q;
  logic          cnt_load;
  logic [3:0]    cnt_load_val;
  logic          cnt_zero;
  logic          attack_req;

  assign attack_req = attack_i & ~prev_attack_q;

  frame_counter u_frame_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (restart_i),
    .tick_i     (frame_tick_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // Next-state decision; only committed by the register process on a tick.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    pos_d        = pos_q;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;

    if (!enable_i) begin
      // Abort anything in progress; position holds.
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_WALK_L, ST_WALK_R: begin
          if (attack_req) begin
            state_d      = ST_ATK_STARTUP;
            cnt_load     = 1'b1;
            cnt_load_val = STARTUP_FR - 4'd1;
          end else if (move_left_i && !move_right_i) begin
            state_d = ST_WALK_L;
            pos_d   = step_left(pos_q, WALK_STEP, X_MIN);
          end else if (move_right_i && !move_left_i) begin
            state_d = ST_WALK_R;
            pos_d   = step_right(pos_q, WALK_STEP, X_MAX);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ATK_STARTUP: if (cnt_zero) begin
          state_d      = ST_ATK_ACTIVE;
          cnt_load     = 1'b1;
          cnt_load_val = ACTIVE_FR - 4'd1;
        end
        ST_ATK_ACTIVE: if (cnt_zero) begin
          state_d      = ST_ATK_RECOVER;
          cnt_load     = 1'b1;
          cnt_load_val = RECOVER_FR - 4'd1;
        end
        ST_ATK_RECOVER: if (cnt_zero) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      pos_q          <= X_INIT;
      prev_attack_q  <= 1'b1;  // an attack held through reset must not fire
      hitbox_q       <= 1'b0;
      attack_start_q <= 1'b0;
    end else if (restart_i) begin
      state_q        <= ST_IDLE;
      pos_q          <= X_INIT;
      prev_attack_q  <= 1'b1;
      hitbox_q       <= 1'b0;
      attack_start_q <= 1'b0;
    end else begin
      attack_start_q <= 1'b0;
      if (frame_tick_i) begin
        state_q        <= state_d;
        pos_q          <= pos_d;
        prev_attack_q  <= attack_i;
        // Registered alongside the state so it tracks state_o exactly.
        hitbox_q       <= (state_d == ST_ATK_ACTIVE);
        attack_start_q <= (state_d == ST_ATK_STARTUP) && (state_q != ST_ATK_STARTUP);
      end
    end
  end

  assign pos_x_o         = pos_q;
  assign state_o         = state_q;
  assign hitbox_active_o = hitbox_q;
  assign attack_start_o  = attack_start_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Self-checking bench for player_action_ctrl: a driver pushes expected
// outputs from a frame-level reference model into a scoreboard queue and a
// monitor pops and compares one entry per clock after reset.
module tb_player_action_ctrl;

  localparam int S_IDLE = 0, S_WL = 1, S_WR = 2, S_SU = 3, S_AC = 4, S_RC = 5;
  localparam int XMIN = 16, XMAX = 560, XINIT = 100, STEP = 3;
  localparam int N_SU = 4, N_AC = 3, N_RC = 6;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_tick_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       enable_i = 1'b1;
  logic       move_left_i = 1'b0;
  logic       move_right_i = 1'b0;
  logic       attack_i = 1'b1;
  logic [9:0] pos_x_o;
  logic [2:0] state_o;
  logic       hitbox_active_o;
  logic       attack_start_o;

  player_action_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .frame_tick_i   (frame_tick_i),
    .restart_i      (restart_i),
    .enable_i       (enable_i),
    .move_left_i    (move_left_i),
    .move_right_i   (move_right_i),
    .attack_i       (attack_i),
    .pos_x_o        (pos_x_o),
    .state_o        (state_o),
    .hitbox_active_o(hitbox_active_o),
    .attack_start_o (attack_start_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int st;
    int pos;
    bit hit;
    bit start;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done  = 0;

  // Reference model: phase plus number of ticks left in that phase.
  int m_st, m_pos, m_left;
  bit m_prev, m_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_pos = XINIT; m_left = 0; m_prev = 1; m_start = 0;
  endtask

  task automatic model_step(input bit tk, input bit rs, input bit en,
                            input bit l, input bit r, input bit a);
    bit req;
    if (rs) begin
      model_reset();
      return;
    end
    m_start = 0;
    if (!tk) return;
    req    = a && !m_prev;
    m_prev = a;
    if (!en) begin
      m_st = S_IDLE;
    end else if (m_st == S_SU || m_st == S_AC || m_st == S_RC) begin
      m_left--;
      if (m_left == 0) begin
        if (m_st == S_SU)      begin m_st = S_AC; m_left = N_AC; end
        else if (m_st == S_AC) begin m_st = S_RC; m_left = N_RC; end
        else                   m_st = S_IDLE;
      end
    end else if (req) begin
      m_st = S_SU; m_left = N_SU; m_start = 1;
    end else if (l && !r) begin
      m_st = S_WL; m_pos = (m_pos - STEP < XMIN) ? XMIN : m_pos - STEP;
    end else if (r && !l) begin
      m_st = S_WR; m_pos = (m_pos + STEP > XMAX) ? XMAX : m_pos + STEP;
    end else begin
      m_st = S_IDLE;
    end
  endtask

  // One clock cycle of stimulus; expectation is for after the next edge.
  task automatic cyc(input bit tk, input bit rs, input bit en,
                     input bit l, input bit r, input bit a);
    exp_t e;
    @(negedge clk_i);
    frame_tick_i = tk; restart_i = rs; enable_i = en;
    move_left_i = l; move_right_i = r; attack_i = a;
    model_step(tk, rs, en, l, r, a);
    e.st = m_st; e.pos = m_pos; e.hit = (m_st == S_AC); e.start = m_start;
    sb_q.push_back(e);
  endtask

  // A tick followed by a quiet cycle, so holding between ticks is exercised.
  task automatic frame(input bit l, input bit r, input bit a, input bit en = 1'b1);
    cyc(1'b1, 1'b0, en, l, r, a);
    cyc(1'b0, 1'b0, en, l, r, a);
  endtask

  task automatic check_reset_outputs();
    check("rst_pos", pos_x_o, XINIT);
    check("rst_state", state_o, S_IDLE);
    check("rst_hitbox", hitbox_active_o, 0);
    check("rst_start", attack_start_o, 0);
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #3 rst_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk_i);
    release_reset();
  endtask

  // Monitor: one scoreboard entry per clock outside reset.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk_i);
      #2;
      if (rst_i) continue;
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_underflow: got no expectation at t=%0t", $time);
        continue;
      end
      e = sb_q.pop_front();
      check("state", state_o, e.st);
      check("pos", pos_x_o, e.pos);
      check("hitbox", hitbox_active_o, e.hit);
      check("attack_start", attack_start_o, e.start);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tk, rs, en, l, r, a;
    model_reset();
    // Reset with attack held: it must not fire afterwards.
    #12 check_reset_outputs();
    release_reset();
    repeat (3) frame(0, 0, 1);
    repeat (2) frame(0, 0, 0);
    // Rising edge then held for 20 ticks: exactly one full attack sequence.
    repeat (20) frame(0, 0, 1);
    repeat (2) frame(0, 0, 0);
    // Walk to both saturation limits.
    repeat (160) cyc(1, 0, 1, 0, 1, 0);
    repeat (185) cyc(1, 0, 1, 1, 0, 0);
    // Both directions: idle, no move.
    repeat (2) frame(1, 1, 0);
    // Attack together with right: attack wins, no move during attack.
    frame(0, 0, 0);
    repeat (15) frame(0, 1, 1);
    // Restart during ATK_ACTIVE (after moving away from X_INIT).
    repeat (4) frame(0, 1, 0);
    frame(0, 0, 0);
    frame(0, 0, 1);
    repeat (4) frame(0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    repeat (3) frame(0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);   // tick and restart together: restart wins
    repeat (2) frame(0, 0, 0);
    // Drop enable during ATK_STARTUP: abort, no hitbox.
    frame(0, 0, 1);
    frame(0, 0, 0);
    frame(0, 0, 0, 0);
    repeat (8) frame(0, 0, 0);
    // Asynchronous reset mid-attack.
    frame(0, 0, 1);
    repeat (5) frame(0, 0, 0);
    do_reset();
    repeat (3) frame(0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      tk = ($urandom_range(0, 1) == 0);
      rs = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 15) != 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 3) == 0);
      cyc(tk, rs, en, l, r, a);
    end
    @(posedge clk_i);
    #4;
    done = 1;
    if (sb_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
